// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: FSM encodings, control-bundle layout and the
// hazard-match helper used by the sequencing controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int CB_GPRWR    = 7;
  localparam int CB_BSEL     = 6;
  localparam int CB_DMWR     = 5;
  localparam int CB_MTR      = 4;
  localparam int CB_ALUOP_HI = 3;
  localparam int CB_ALUOP_LO = 0;

  localparam logic [7:0] CB_NOP   = 8'h00;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_en;
    logic memwb_en;
  } pipe_ctl_t;

  // Source operand in ID reads the register the EX instruction will write.
  function automatic logic src_hit(input logic used, input logic [4:0] src,
                                   input logic [4:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_wdog.sv
// Consecutive-busy-cycle counter with a sticky timeout flag; usable for any
// memory port that can stall the pipeline.
module hazard_ctrl_wdog #(
  parameter int MAX = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  output logic timeout
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] LIM = CW'(MAX);

  logic [CW-1:0] cnt, cnt_nxt;

  assign cnt_nxt = (cnt == LIM) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (busy) begin
      cnt <= cnt_nxt;
      if (cnt_nxt == LIM) timeout <= 1'b1;
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencing controller: load-use stall, EX-resolved branch
// flush, data-memory freeze with watchdog. HAZARD_CTRL_BUBBLE_CNT_EN adds a
// bubble counter output.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_lw,
  input  logic             i_br_taken,
  input  logic             i_dm_busy,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_exmem_en,
  output logic             o_memwb_en,
  output logic             o_timeout,
`ifdef HAZARD_CTRL_BUBBLE_CNT_EN
  output logic [CNT_W-1:0] o_bubble_cnt,
`endif
  output logic [1:0]       o_state
);

  state_e    state, state_nxt;
  logic      br_pend, br_pend_nxt;
  logic      lu_hz, br;
  pipe_ctl_t ctl;

  assign lu_hz = i_ex_lw && (i_ex_rd != REG_ZERO) &&
                 (src_hit(i_id_use_rs, i_id_rs, i_ex_rd) ||
                  src_hit(i_id_use_rt, i_id_rt, i_ex_rd));
  assign br    = i_br_taken || br_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      br_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      br_pend <= br_pend_nxt;
    end
  end

  // Decisions depend only on current inputs plus br_pend; state is kept for
  // visibility. Outputs are held low combinationally while in reset.
  always_comb begin
    ctl         = '0;
    state_nxt   = RUN;
    br_pend_nxt = br_pend;
    if (!rst_n) begin
      ctl = '0;
    end else if (i_dm_busy) begin
      state_nxt   = WAIT;
      br_pend_nxt = br_pend || i_br_taken;
    end else if (br) begin
      ctl         = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      br_pend_nxt = 1'b0;
    end else if (lu_hz) begin
      ctl       = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      state_nxt = STALL;
    end else begin
      ctl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    end
  end

  hazard_ctrl_wdog #(.MAX(MEM_TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (i_dm_busy),
    .timeout (o_timeout)
  );

`ifdef HAZARD_CTRL_BUBBLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               o_bubble_cnt <= '0;
    else if (ctl.idex_bubble) o_bubble_cnt <= o_bubble_cnt + 1'b1;
  end
`endif

  assign o_pc_en       = ctl.pc_en;
  assign o_ifid_en     = ctl.ifid_en;
  assign o_ifid_flush  = ctl.ifid_flush;
  assign o_idex_bubble = ctl.idex_bubble;
  assign o_exmem_en    = ctl.exmem_en;
  assign o_memwb_en    = ctl.memwb_en;
  assign o_state       = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// expectations from a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int MT    = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic use_rs = 1'b0, use_rt = 1'b0, ex_lw = 1'b0, br_taken = 1'b0, dm_busy = 1'b0;
  logic pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en, timeout;
  logic [1:0] state;
`ifdef HAZARD_CTRL_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(use_rs), .i_id_use_rt(use_rt),
    .i_ex_rd(ex_rd), .i_ex_lw(ex_lw), .i_br_taken(br_taken), .i_dm_busy(dm_busy),
    .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush),
    .o_idex_bubble(idex_bubble), .o_exmem_en(exmem_en), .o_memwb_en(memwb_en),
    .o_timeout(timeout),
`ifdef HAZARD_CTRL_BUBBLE_CNT_EN
    .o_bubble_cnt(bubble_cnt),
`endif
    .o_state(state)
  );

  typedef struct {
    int          tag;
    logic [8:0]  outs;   // {pc,ifid,flush,bubble,exmem,memwb,timeout,state}
    int unsigned bcnt;
  } exp_t;

  exp_t q[$];
  int compared = 0, mismatched = 0;

  // Model state: plain counters and flags, not the DUT's encoding.
  int   m_busy_run = 0, m_bcnt = 0, m_tag = 0;
  bit   m_pend = 0, m_tout = 0;
  logic [1:0] m_state = 2'd0;

  task automatic step(input bit rst, input bit busy, input bit brt, input bit lw,
                      input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                      input bit urs, input bit urt);
    exp_t e;
    bit lu, br, pc, ie, fl, bu, em, mw;
    @(negedge clk);
    rst_n = rst; dm_busy = busy; br_taken = brt; ex_lw = lw; ex_rd = rd;
    id_rs = rs; id_rt = rt; use_rs = urs; use_rt = urt;
    #1;
    lu = lw && rd != 0 && ((urs && rs == rd) || (urt && rt == rd));
    br = brt || m_pend;
    {pc, ie, fl, bu, em, mw} = '0;
    if (!rst) begin
      m_state = 0; m_pend = 0; m_tout = 0; m_busy_run = 0; m_bcnt = 0;
    end
    e.tag  = m_tag++;
    e.bcnt = m_bcnt;
    if (rst) begin
      if (busy) begin
        // outputs all low
      end else if (br) begin
        {pc, ie, fl, bu, em, mw} = 6'b111111;
      end else if (lu) begin
        {pc, ie, fl, bu, em, mw} = 6'b000111;
      end else begin
        {pc, ie, fl, bu, em, mw} = 6'b110011;
      end
    end
    e.outs = {pc, ie, fl, bu, em, mw, m_tout, m_state};
    q.push_back(e);
    if (rst) begin
      if (busy) begin
        m_pend = m_pend || brt;
        m_busy_run++;
        if (m_busy_run >= MT) m_tout = 1;
        m_state = 2;
      end else begin
        m_busy_run = 0;
        if (br) begin m_pend = 0; m_state = 0; end
        else m_state = lu ? 2'd1 : 2'd0;
      end
      if (bu) m_bcnt = (m_bcnt + 1) % (1 << CNT_W);
    end
  endtask

  task automatic idle(input bit busy, input bit brt);
    step(1, busy, brt, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        compared++;
        if ({pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en, timeout, state} !== e.outs) begin
          mismatched++;
          $display("FAIL outs step %0d: got %b want %b", e.tag,
                   {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en, timeout, state}, e.outs);
        end
`ifdef HAZARD_CTRL_BUBBLE_CNT_EN
        compared++;
        if (bubble_cnt !== CNT_W'(e.bcnt)) begin
          mismatched++;
          $display("FAIL bubble_cnt step %0d: got %0d want %0d", e.tag, bubble_cnt, e.bcnt);
        end
`endif
      end
    end
  end

  initial begin : stim
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 5, 5, 5, 1, 1);      // reset holds outputs low despite inputs
    idle(0, 0);
    // load-use on rs, then clear
    step(1, 0, 0, 1, 5, 5, 0, 1, 0);
    idle(0, 0);
    // rt path, and no false hazards
    step(1, 0, 0, 1, 7, 0, 7, 0, 1);
    step(1, 0, 0, 1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 5, 5, 0, 0, 0);
    // stall held while hazard persists
    step(1, 0, 0, 1, 3, 3, 0, 1, 0);
    step(1, 0, 0, 1, 3, 3, 0, 1, 0);
    idle(0, 0);
    // branch beats load-use
    step(1, 0, 1, 1, 5, 5, 0, 1, 0);
    idle(0, 0);
    // branch during busy, applied on first free cycle
    idle(1, 0); idle(1, 1); idle(1, 0);
    idle(0, 0); idle(0, 0);
    // watchdog: 6 busy cycles then sticky
    repeat (6) idle(1, 0);
    idle(0, 0); idle(0, 0);
    // async reset mid-WAIT
    idle(1, 1); idle(1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [4:0] rd, rs, rt;
      rd = 5'($urandom_range(0, 3));
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 6) == 0), $urandom_range(0, 1) == 1, rd, rs, rt,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    idle(0, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #3;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
